viterbi_ctrl: RTL and testbench

//  Frame sequencer for the K=3 Viterbi decoder datapath (bmc x8 -> ACS x4 -> survivor memory -> traceback).
//  - Accepts a stream of received 2-bit symbol pairs with a valid/ready handshake.
//  - Enables the BMC/ACS stage one symbol per cycle and generates survivor-memory write and read addresses.
//  - Runs traceback once the frame ends, then streams decoded bits back out in forward order.
//  - Pure control: no metric arithmetic. Data buses go straight from the ports to the datapath.

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/viterbi_addr_cnt.sv | 35 +++
 rtl/viterbi_ctrl.sv | 160 ++++++++++++++++
 tb/tb_viterbi_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// ----------------------------------------------------------------------------
// viterbi_pkg
// Shared types and constants for the K=3 Viterbi decoder control path.
//   vit_state_t  : frame sequencer states
//   VIT_MAX_LEN  : default maximum frame length in symbols
// ----------------------------------------------------------------------------
package viterbi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        FLUSH,
        TRACE,
        DRAIN,
        OUT
    } vit_state_t;

    localparam int VIT_MAX_LEN = 256;

endpackage

// File: rtl/viterbi_addr_cnt.sv
// ----------------------------------------------------------------------------
// viterbi_addr_cnt
// ADDR_W-bit address counter with synchronous load, increment, decrement and
// hold. Priority: load > increment > decrement > hold.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   ld, ld_val : load ld_val on the next edge
//   inc, dec   : count up / down by one
//   cnt        : current counter value
// ----------------------------------------------------------------------------
module viterbi_addr_cnt #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_val,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc) begin
            cnt <= cnt + ADDR_W'(1);
        end else if (dec) begin
            cnt <= cnt - ADDR_W'(1);
        end
    end

endmodule

// File: rtl/viterbi_ctrl.sv
// ----------------------------------------------------------------------------
// viterbi_ctrl
// Frame sequencer for the K=3 Viterbi decoder datapath. Accepts received
// symbol pairs, enables BMC/ACS one symbol per cycle, writes survivors,
// runs traceback after the frame ends and streams the decoded bits out in
// forward order. Pure control; no metric arithmetic.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_last/in_ready  : input symbol handshake
//   acs_en, acs_init           : ACS update strobe / use initial metrics
//   mem_wr_en, mem_wr_addr     : survivor-memory write port
//   mem_rd_addr                : survivor-memory read address (traceback)
//   tb_start, tb_en            : traceback load-best-state / step-back
//   dec_wr_en, dec_wr_addr     : decoded-bit buffer write port
//   out_valid/out_last/out_ready, out_addr : decoded-bit output handshake
//   len_err                    : pulse when a frame is truncated at MAX_LEN
//   busy                       : any state other than IDLE
// ----------------------------------------------------------------------------
module viterbi_ctrl
    import viterbi_pkg::*;
#(
    parameter int MAX_LEN = VIT_MAX_LEN,
    parameter int ADDR_W  = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              acs_en,
    output logic              acs_init,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              tb_start,
    output logic              tb_en,
    output logic              dec_wr_en,
    output logic [ADDR_W-1:0] dec_wr_addr,
    output logic              out_valid,
    output logic              out_last,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ready,
    output logic              len_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(MAX_LEN - 1);

    vit_state_t        state;
    logic              acc;
    logic              at_max;
    logic              last_acc;
    logic              beat;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] oaddr;
    // Frame length minus one; avoids an extra bit for len = MAX_LEN.
    logic [ADDR_W-1:0] len_m1;

    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic              dec_vld_p1;
    logic [ADDR_W-1:0] dec_addr_p1;
    logic              tb_start_p1;

    // rst_n is folded in so in_ready is low while reset is asserted.
    assign in_ready = rst_n & ((state == IDLE) | (state == FWD));
    assign acc      = in_valid & in_ready;
    assign at_max   = (cnt == CNT_MAX);
    // in_last at cnt = MAX_LEN-1 is a normal end; only a missing in_last truncates.
    assign last_acc = acc & (in_last | at_max);
    assign len_err  = acc & at_max & ~in_last;

    assign acs_en   = acc;
    assign acs_init = acc & (state == IDLE);

    assign tb_en       = (state == TRACE);
    assign tb_start    = tb_start_p1;
    assign mem_rd_addr = rd_addr;

    assign out_valid = (state == OUT);
    assign out_addr  = oaddr;
    assign out_last  = out_valid & (oaddr == len_m1);
    assign beat      = out_valid & out_ready;

    assign busy = (state != IDLE);

    assign mem_wr_en   = wr_vld_p1;
    assign mem_wr_addr = wr_addr_p1;
    assign dec_wr_en   = dec_vld_p1;
    assign dec_wr_addr = dec_addr_p1;

    // Symbol counter: cleared at the end of each frame so the next starts at 0.
    viterbi_addr_cnt #(.ADDR_W(ADDR_W)) u_fwd_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (last_acc),
        .ld_val ('0),
        .inc    (acc & ~last_acc),
        .dec    (1'b0),
        .cnt    (cnt)
    );

    // Traceback read address: loaded during FLUSH, counts down to 0 in TRACE.
    viterbi_addr_cnt #(.ADDR_W(ADDR_W)) u_rd_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (state == FLUSH),
        .ld_val (len_m1),
        .inc    (1'b0),
        .dec    (tb_en & (rd_addr != '0)),
        .cnt    (rd_addr)
    );

    // Output read address: advances per beat, returns to 0 on the last beat.
    viterbi_addr_cnt #(.ADDR_W(ADDR_W)) u_out_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (beat & out_last),
        .ld_val ('0),
        .inc    (beat & ~out_last),
        .dec    (1'b0),
        .cnt    (oaddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_m1      <= '0;
            wr_vld_p1   <= 1'b0;
            wr_addr_p1  <= '0;
            dec_vld_p1  <= 1'b0;
            dec_addr_p1 <= '0;
            tb_start_p1 <= 1'b0;
        end else begin
            // p0 -> p1: survivor write trails the accepted symbol by one cycle
            wr_vld_p1   <= acc;
            wr_addr_p1  <= cnt;
            // p0 -> p1: decoded write trails the survivor read by one cycle
            dec_vld_p1  <= tb_en;
            dec_addr_p1 <= rd_addr;
            tb_start_p1 <= (state == FLUSH);

            if (last_acc) begin
                len_m1 <= cnt;
            end

            case (state)
                IDLE:    if (acc) state <= last_acc ? FLUSH : FWD;
                FWD:     if (last_acc) state <= FLUSH;
                FLUSH:   state <= TRACE;
                TRACE:   if (rd_addr == '0) state <= DRAIN;
                DRAIN:   state <= OUT;
                OUT:     if (beat & out_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// ----------------------------------------------------------------------------
// tb_viterbi_ctrl
// Bench for viterbi_ctrl (MAX_LEN = 8). A frame-timeline model predicts
// every output each cycle from the number of accepted symbols and the
// cycles elapsed since the frame ended; directed frames are followed by
// randomized traffic with occasional resets.
// ----------------------------------------------------------------------------
module tb_viterbi_ctrl;

    localparam int MAXL = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, acs_en, acs_init, mem_wr_en, tb_start, tb_en;
    logic          dec_wr_en, out_valid, out_last, len_err, busy;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr, dec_wr_addr, out_addr;

    viterbi_ctrl #(.MAX_LEN(MAXL), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .acs_en      (acs_en),
        .acs_init    (acs_init),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_rd_addr (mem_rd_addr),
        .tb_start    (tb_start),
        .tb_en       (tb_en),
        .dec_wr_en   (dec_wr_en),
        .dec_wr_addr (dec_wr_addr),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_addr    (out_addr),
        .out_ready   (out_ready),
        .len_err     (len_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame-timeline model: m_mode 0 = collecting symbols (m_n so far),
    // m_mode 1 = frame of length m_L ended, m_k cycles ago (k=1 first cycle after).
    int m_mode = 0, m_n = 0, m_k = 0, m_L = 1, m_beat = 0, m_pidx = 0;
    bit m_pacc = 0;

    // Event monitors read by the directed tests.
    int mon_tb, mon_start, mon_beats, mon_lastaddr, mon_lerr, mon_rdy;
    int mon_cyc = 0, gap_start = 0, gap_meas = -1;
    bit gap_pend = 0;

    always @(negedge clk) begin : cmp
        bit recv, acc, lst, tbe, dwe, ov;
        mon_cyc++;
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_acs_en", acs_en, 0);
            chk("rst_acs_init", acs_init, 0);
            chk("rst_mem_wr_en", mem_wr_en, 0);
            chk("rst_mem_wr_addr", mem_wr_addr, 0);
            chk("rst_mem_rd_addr", mem_rd_addr, 0);
            chk("rst_tb_start", tb_start, 0);
            chk("rst_tb_en", tb_en, 0);
            chk("rst_dec_wr_en", dec_wr_en, 0);
            chk("rst_dec_wr_addr", dec_wr_addr, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_addr", out_addr, 0);
            chk("rst_len_err", len_err, 0);
            chk("rst_busy", busy, 0);
            m_mode = 0; m_n = 0; m_k = 0; m_beat = 0; m_pacc = 0; m_pidx = 0;
            gap_pend = 0;
        end else begin
            recv = (m_mode == 0);
            acc  = in_valid && recv;
            lst  = acc && (in_last || m_n == MAXL - 1);
            tbe  = (m_mode == 1) && m_k >= 2 && m_k <= m_L + 1;
            dwe  = (m_mode == 1) && m_k >= 3 && m_k <= m_L + 2;
            ov   = (m_mode == 1) && m_k >= m_L + 3;

            chk("in_ready", in_ready, recv);
            chk("acs_en", acs_en, acc);
            chk("acs_init", acs_init, acc && m_n == 0);
            chk("len_err", len_err, acc && m_n == MAXL - 1 && !in_last);
            chk("busy", busy, !(recv && m_n == 0));
            chk("mem_wr_en", mem_wr_en, m_pacc);
            if (m_pacc) chk("mem_wr_addr", mem_wr_addr, m_pidx);
            chk("tb_start", tb_start, (m_mode == 1) && m_k == 2);
            chk("tb_en", tb_en, tbe);
            if (tbe) chk("mem_rd_addr", mem_rd_addr, m_L + 1 - m_k);
            chk("dec_wr_en", dec_wr_en, dwe);
            if (dwe) chk("dec_wr_addr", dec_wr_addr, m_L + 2 - m_k);
            chk("out_valid", out_valid, ov);
            chk("out_last", out_last, ov && m_beat == m_L - 1);
            if (ov) chk("out_addr", out_addr, m_beat);

            // monitors
            if (tb_en) mon_tb++;
            if (tb_start) mon_start = mem_rd_addr;
            if (len_err) mon_lerr++;
            if (in_ready && in_valid) mon_rdy++;
            if (acs_en && gap_pend) begin
                gap_meas = mon_cyc - gap_start;
                gap_pend = 0;
            end
            if (out_valid && out_ready) begin
                mon_beats++;
                if (out_last) begin
                    mon_lastaddr = out_addr;
                    gap_pend     = 1;
                    gap_start    = mon_cyc;
                end
            end

            // advance model to the next cycle
            m_pacc = acc;
            m_pidx = m_n;
            if (acc) begin
                if (lst) begin
                    m_mode = 1; m_L = m_n + 1; m_k = 1; m_n = 0; m_beat = 0;
                end else begin
                    m_n++;
                end
            end else if (m_mode == 1) begin
                if (ov && out_ready) begin
                    if (m_beat == m_L - 1) begin
                        m_mode = 0; m_beat = 0;
                    end else begin
                        m_beat++;
                    end
                end
                m_k++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_tb = 0; mon_start = -1; mon_beats = 0; mon_lastaddr = -1;
        mon_lerr = 0; mon_rdy = 0; gap_meas = -1;
    endtask

    task automatic wait_idle(input string nm);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        chk({nm, "_idle"}, done, 1);
        step();
    endtask

    task automatic send(input int n, input int gap, input bit with_last);
        bit ok;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_last  = with_last && (i == n - 1);
            ok = 0;
            for (int t = 0; t < 300 && !ok; t++) begin
                @(negedge clk);
                ok = in_ready;
                step();
            end
            if (!ok) chk("send_accept", ok, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            repeat (gap) step();
        end
    endtask

    initial begin : stim
        bit seen;
        logic [3:0] pat;
        pat = 4'b1001;  // out_ready sequence 1,0,0,1 (bit 3 first)

        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        step();

        // 8-symbol frame, back-to-back symbols, last at cnt = MAX_LEN-1
        clr_mon();
        out_ready = 1'b1;
        send(8, 0, 1'b1);
        wait_idle("t2");
        chk("t2_start_addr", mon_start, 7);
        chk("t2_tb_cycles", mon_tb, 8);
        chk("t2_beats", mon_beats, 8);
        chk("t2_last_addr", mon_lastaddr, 7);
        chk("t2_len_err", mon_lerr, 0);

        // same frame with 2-cycle gaps
        clr_mon();
        send(8, 2, 1'b1);
        wait_idle("t3");
        chk("t3_tb_cycles", mon_tb, 8);
        chk("t3_beats", mon_beats, 8);

        // truncation: 10 symbols, no in_last
        clr_mon();
        in_valid = 1'b1;
        repeat (10) step();
        in_valid = 1'b0;
        wait_idle("t4");
        chk("t4_len_err", mon_lerr, 1);
        chk("t4_accepted", mon_rdy, 8);
        chk("t4_beats", mon_beats, 8);
        chk("t4_last_addr", mon_lastaddr, 7);

        // 1-symbol frame
        clr_mon();
        send(1, 0, 1'b1);
        wait_idle("t5");
        chk("t5_tb_cycles", mon_tb, 1);
        chk("t5_start_addr", mon_start, 0);
        chk("t5_beats", mon_beats, 1);
        chk("t5_last_addr", mon_lastaddr, 0);

        // reset in the middle of TRACE
        clr_mon();
        send(8, 0, 1'b1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = tb_en && (mem_rd_addr == 3'd4);
        end
        chk("t1_reached_trace", seen, 1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t1_busy", busy, 0);
        chk("t1_tb_en", tb_en, 0);
        chk("t1_dec_wr_en", dec_wr_en, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_busy_after", busy, 0);
        step();

        // output stalls, then frame 2 pending during OUT
        clr_mon();
        out_ready = 1'b0;
        send(4, 0, 1'b1);
        in_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("t6_reached_out", seen, 1);
        step();
        for (int i = 0; i < 40 && gap_meas < 0; i++) begin
            out_ready = pat[3 - (i % 4)];
            step();
        end
        chk("t6_last_addr", mon_lastaddr, 3);
        chk("t6_accept_gap", gap_meas, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(1, 0, 1'b1);
        wait_idle("t6");

        // randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        out_ready = 1'b1;
        wait_idle("rnd_drain1");
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle("rnd_drain2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
